// File: rtl/ip_codma_crc_pkg.sv
// Shared types, polynomial presets and helpers for the CoDMA streaming CRC block.
package ip_codma_crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } crc_state_e;

    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w) begin
                r[i[4:0]] = v[5'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ip_codma_crc_step.sv
// Combinational fold of BITS_PER_CYCLE message bits into a CRC, bits_i MSB first.
// Zero latency, no flow control.
module ip_codma_crc_step #(
    parameter int                CRC_W          = 16,
    parameter logic [CRC_W-1:0]  POLY           = 'h1021,
    parameter int                BITS_PER_CYCLE = 8
) (
    input  logic [CRC_W-1:0]          crc_i,
    input  logic [BITS_PER_CYCLE-1:0] bits_i,
    output logic [CRC_W-1:0]          crc_o
);

    logic [CRC_W-1:0] acc;
    logic             fb;

    always_comb begin
        acc = crc_i;
        fb  = 1'b0;
        for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
            fb  = acc[CRC_W-1] ^ bits_i[i];
            acc = {acc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        crc_o = acc;
    end

endmodule

// File: rtl/ip_codma_crc_stream.sv
// Streaming CRC: one word accepted per N+1 cycles (N = DATA_W/BITS_PER_CYCLE), result held in DONE
// until crc_ready_i; data_ready_o only in IDLE. CODMA_CRC_CHECK_EN enables the crc_match_o comparator.
module ip_codma_crc_stream
    import ip_codma_crc_pkg::*;
#(
    parameter int                CRC_W          = 16,
    parameter logic [CRC_W-1:0]  POLY           = 'h1021,
    parameter logic [CRC_W-1:0]  INIT           = 'hFFFF,
    parameter logic [CRC_W-1:0]  XOR_OUT        = 'h0000,
    parameter int                DATA_W         = 32,
    parameter int                BITS_PER_CYCLE = 8,
    parameter bit                REFLECT_IN     = 1'b0,
    parameter bit                REFLECT_OUT    = 1'b0
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_valid_i,
    input  logic              data_last_i,
    output logic              data_ready_o,
    output logic [CRC_W-1:0]  crc_o,
    output logic              crc_valid_o,
    input  logic              crc_ready_i,
    input  logic [CRC_W-1:0]  expect_i,
    output logic              crc_match_o
);

    localparam int N      = DATA_W / BITS_PER_CYCLE;
    localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

    if (CRC_W < 8 || CRC_W > 32) begin : g_bad_crc_w
        $error("ip_codma_crc_stream: CRC_W must be within 8..32");
    end
    if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > DATA_W) begin : g_bad_bpc
        $error("ip_codma_crc_stream: BITS_PER_CYCLE must be within 1..DATA_W");
    end
    if ((DATA_W % BITS_PER_CYCLE) != 0) begin : g_bad_div
        $error("ip_codma_crc_stream: DATA_W must be a multiple of BITS_PER_CYCLE");
    end

    crc_state_e        state_q;
    logic [CRC_W-1:0]  crc_q;
    logic [CRC_W-1:0]  crc_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_ord;
    logic              last_q;
    logic [BEAT_W-1:0] beat_q;
    logic              ready_q;
    logic              valid_q;
    logic [CRC_W-1:0]  crc_rev;
    logic [CRC_W-1:0]  crc_fin;

    // The word is stored in feed order so SHIFT always consumes the top bits.
    always_comb begin
        data_ord = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data_ord[i] = REFLECT_IN ? data_i[DATA_W-1-i] : data_i[i];
        end
    end

    ip_codma_crc_step #(
        .CRC_W          (CRC_W),
        .POLY           (POLY),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .crc_i  (crc_q),
        .bits_i (data_q[DATA_W-1 -: BITS_PER_CYCLE]),
        .crc_o  (crc_d)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            crc_q   <= INIT;
            data_q  <= '0;
            last_q  <= 1'b0;
            beat_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            state_q <= ST_IDLE;
            crc_q   <= INIT;
            beat_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (data_valid_i && ready_q) begin
                        data_q  <= data_ord;
                        last_q  <= data_last_i;
                        beat_q  <= '0;
                        ready_q <= 1'b0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    crc_q  <= crc_d;
                    data_q <= data_q << BITS_PER_CYCLE;
                    beat_q <= beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_q <= '0;
                        if (last_q) begin
                            valid_q <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (crc_ready_i) begin
                        crc_q   <= INIT;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign crc_rev      = CRC_W'(bitrev(32'(crc_q), CRC_W));
    assign crc_fin      = (REFLECT_OUT ? crc_rev : crc_q) ^ XOR_OUT;
    assign crc_o        = valid_q ? crc_fin : '0;
    assign crc_valid_o  = valid_q;
    assign data_ready_o = ready_q;

`ifdef CODMA_CRC_CHECK_EN
    assign crc_match_o = valid_q && (crc_o == expect_i);
`else
    logic expect_unused;
    assign expect_unused = ^expect_i;
    assign crc_match_o   = 1'b0;
`endif

endmodule

// File: tb/tb_ip_codma_crc_stream.sv
// Directed bench: CCITT-FALSE, XMODEM and CRC-32 check vectors plus flow-control, abort and reset cases.
module tb_ip_codma_crc_stream;
    import ip_codma_crc_pkg::*;

`ifdef CODMA_CRC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, clr;
    // Three 8-bit instances driven in lockstep
    logic [7:0]  d8;
    logic        v8, l8, cr8;
    logic [15:0] exp_a;
    logic        rdy_a, rdy_x, rdy_c, val_a, val_x, val_c, match_a, match_x, match_c;
    logic [15:0] crc_a, crc_x;
    logic [31:0] crc_c;
    // 32-bit XMODEM instance
    logic [31:0] d32;
    logic        v32, l32, cr32, rdy_w, val_w, match_w;
    logic [15:0] crc_w;

    int total = 0;
    int bad   = 0;

    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    ip_codma_crc_stream #(.DATA_W(8), .BITS_PER_CYCLE(8)) u_ccitt (
        .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr), .data_i(d8), .data_valid_i(v8),
        .data_last_i(l8), .data_ready_o(rdy_a), .crc_o(crc_a), .crc_valid_o(val_a),
        .crc_ready_i(cr8), .expect_i(exp_a), .crc_match_o(match_a));

    ip_codma_crc_stream #(.INIT(16'h0000), .DATA_W(8), .BITS_PER_CYCLE(8)) u_xm8 (
        .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr), .data_i(d8), .data_valid_i(v8),
        .data_last_i(l8), .data_ready_o(rdy_x), .crc_o(crc_x), .crc_valid_o(val_x),
        .crc_ready_i(cr8), .expect_i(16'h31C3), .crc_match_o(match_x));

    ip_codma_crc_stream #(.CRC_W(32), .POLY(CRC32_POLY), .INIT(32'hFFFFFFFF),
        .XOR_OUT(32'hFFFFFFFF), .DATA_W(8), .BITS_PER_CYCLE(8),
        .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)) u_crc32 (
        .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr), .data_i(d8), .data_valid_i(v8),
        .data_last_i(l8), .data_ready_o(rdy_c), .crc_o(crc_c), .crc_valid_o(val_c),
        .crc_ready_i(cr8), .expect_i(32'hCBF43926), .crc_match_o(match_c));

    ip_codma_crc_stream #(.INIT(16'h0000), .DATA_W(32), .BITS_PER_CYCLE(4)) u_xm32 (
        .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr), .data_i(d32), .data_valid_i(v32),
        .data_last_i(l32), .data_ready_o(rdy_w), .crc_o(crc_w), .crc_valid_o(val_w),
        .crc_ready_i(cr32), .expect_i(16'h0000), .crc_match_o(match_w));

    // Bit-serial XMODEM reference for one 32-bit word
    function automatic logic [15:0] xmodem_word(input logic [31:0] w);
        logic [15:0] c;
        c = 16'h0000;
        for (int i = 31; i >= 0; i--) begin
            if (c[15] ^ w[i]) c = (c << 1) ^ 16'h1021;
            else              c = c << 1;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        while (!(rdy_a && rdy_x && rdy_c) && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n >= 20) begin bad++; $display("FAIL send8_ready_timeout rdy=%b%b%b want=111", rdy_a, rdy_x, rdy_c); end
        d8 = b; l8 = last; v8 = 1'b1;
        tick();
        v8 = 1'b0; l8 = 1'b0;
    endtask

    task automatic send32(input logic [31:0] w, input logic last);
        int n;
        n = 0;
        while (!rdy_w && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n >= 40) begin bad++; $display("FAIL send32_ready_timeout rdy=%b want=1", rdy_w); end
        d32 = w; l32 = last; v32 = 1'b1;
        tick();
        v32 = 1'b0; l32 = 1'b0;
    endtask

    // Sends "123456789"; returns one cycle after the last acceptance (still in SHIFT).
    task automatic send_msg();
        for (int i = 0; i < 9; i++) send8(msg[i], (i == 8));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; v8 = 1'b0; l8 = 1'b0; cr8 = 1'b0; d8 = '0; exp_a = 16'h29B1;
        v32 = 1'b0; l32 = 1'b0; cr32 = 1'b0; d32 = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (val_a !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", val_a); end
        total++; if (crc_a !== 16'h0000) begin bad++; $display("FAIL rst_crc got=%h want=0000", crc_a); end
        total++; if (match_a !== 1'b0) begin bad++; $display("FAIL rst_match got=%b want=0", match_a); end
        total++; if (crc_c !== 32'h0) begin bad++; $display("FAIL rst_crc32 got=%h want=00000000", crc_c); end
        rst_n = 1'b1;
        tick();
        total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL rst_ready_after_release got=%b want=1", rdy_a); end
        total++; if (rdy_w !== 1'b1) begin bad++; $display("FAIL rst_ready32_after_release got=%b want=1", rdy_w); end
    endtask

    task automatic test_vectors();
        exp_a = 16'h29B1;
        send_msg();
        total++; if (val_a !== 1'b0) begin bad++; $display("FAIL vec_early_valid got=%b want=0", val_a); end
        tick();
        total++; if (val_a !== 1'b1) begin bad++; $display("FAIL vec_valid_latency got=%b want=1", val_a); end
        total++; if (crc_a !== 16'h29B1) begin bad++; $display("FAIL vec_ccitt got=%h want=29b1", crc_a); end
        total++; if (crc_x !== 16'h31C3) begin bad++; $display("FAIL vec_xmodem8 got=%h want=31c3", crc_x); end
        total++; if (crc_c !== 32'hCBF43926) begin bad++; $display("FAIL vec_crc32 got=%h want=cbf43926", crc_c); end
        total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL vec_ready_in_done got=%b want=0", rdy_a); end
        total++; if (match_a !== CHK) begin bad++; $display("FAIL vec_match_ccitt got=%b want=%b", match_a, CHK); end
        total++; if (match_x !== CHK) begin bad++; $display("FAIL vec_match_xmodem got=%b want=%b", match_x, CHK); end
        total++; if (match_c !== CHK) begin bad++; $display("FAIL vec_match_crc32 got=%b want=%b", match_c, CHK); end
        cr8 = 1'b1;
        tick();
        cr8 = 1'b0;
        total++; if (val_a !== 1'b0 || crc_a !== 16'h0000) begin bad++; $display("FAIL vec_after_hs valid=%b crc=%h want 0/0000", val_a, crc_a); end
        total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL vec_idle_after_hs got=%b want=1", rdy_a); end
    endtask

    task automatic test_backpressure();
        exp_a = 16'h29B0;
        send_msg();
        tick();
        for (int k = 0; k < 5; k++) begin
            total++; if (val_a !== 1'b1 || crc_a !== 16'h29B1) begin bad++; $display("FAIL bp_hold[%0d] valid=%b crc=%h want 1/29b1", k, val_a, crc_a); end
            total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=0", k, rdy_a); end
            total++; if (match_a !== 1'b0) begin bad++; $display("FAIL bp_match_wrong_expect[%0d] got=%b want=0", k, match_a); end
            tick();
        end
        cr8 = 1'b1;
        tick();
        cr8 = 1'b0;
        total++; if (rdy_a !== 1'b1 || val_a !== 1'b0) begin bad++; $display("FAIL bp_release ready=%b valid=%b want 1/0", rdy_a, val_a); end
        exp_a = 16'h29B1;
        send_msg();
        tick();
        total++; if (crc_a !== 16'h29B1) begin bad++; $display("FAIL bp_next_msg got=%h want=29b1", crc_a); end
        total++; if (crc_c !== 32'hCBF43926) begin bad++; $display("FAIL bp_next_msg32 got=%h want=cbf43926", crc_c); end
        cr8 = 1'b1;
        tick();
        cr8 = 1'b0;
    endtask

    task automatic test_clear();
        send8(msg[0], 1'b0);
        send8(msg[1], 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if (rdy_a !== 1'b1 || val_a !== 1'b0) begin bad++; $display("FAIL clr_mid_shift ready=%b valid=%b want 1/0", rdy_a, val_a); end
        // word offered together with clear must be dropped
        d8 = 8'hA5; v8 = 1'b1; l8 = 1'b1; clr = 1'b1;
        tick();
        v8 = 1'b0; l8 = 1'b0; clr = 1'b0;
        total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL clr_blocks_accept ready=%b want=1", rdy_a); end
        send_msg();
        tick();
        total++; if (crc_a !== 16'h29B1) begin bad++; $display("FAIL clr_rerun got=%h want=29b1", crc_a); end
        total++; if (crc_x !== 16'h31C3) begin bad++; $display("FAIL clr_rerun_xm got=%h want=31c3", crc_x); end
        // clear in DONE overrides a same-cycle handshake
        clr = 1'b1; cr8 = 1'b1;
        tick();
        clr = 1'b0; cr8 = 1'b0;
        total++; if (val_a !== 1'b0 || crc_a !== 16'h0000) begin bad++; $display("FAIL clr_in_done valid=%b crc=%h want 0/0000", val_a, crc_a); end
        send_msg();
        tick();
        total++; if (crc_a !== 16'h29B1) begin bad++; $display("FAIL clr_done_rerun got=%h want=29b1", crc_a); end
        cr8 = 1'b1;
        tick();
        cr8 = 1'b0;
    endtask

    task automatic test_reset_mid();
        send8(msg[0], 1'b0);
        send8(msg[1], 1'b0);
        rst_n = 1'b0;
        #1;
        total++; if (val_a !== 1'b0 || rdy_a !== 1'b0) begin bad++; $display("FAIL rstmid_outputs valid=%b ready=%b want 0/0", val_a, rdy_a); end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", rdy_a); end
        send_msg();
        tick();
        total++; if (crc_a !== 16'h29B1) begin bad++; $display("FAIL rstmid_rerun got=%h want=29b1", crc_a); end
        rst_n = 1'b0;
        #1;
        total++; if (val_a !== 1'b0 || crc_a !== 16'h0000 || match_a !== 1'b0) begin bad++; $display("FAIL rst_in_done valid=%b crc=%h match=%b want 0/0000/0", val_a, crc_a, match_a); end
        tick();
        rst_n = 1'b1;
        tick();
        send_msg();
        tick();
        total++; if (crc_a !== 16'h29B1) begin bad++; $display("FAIL rstdone_rerun got=%h want=29b1", crc_a); end
        cr8 = 1'b1;
        tick();
        cr8 = 1'b0;
    endtask

    task automatic test_xmodem32();
        logic [15:0] want;
        // "123456789" followed by its XMODEM CRC 31C3 and a zero byte leaves a zero residue
        send32(32'h31323334, 1'b0);
        send32(32'h35363738, 1'b0);
        send32(32'h3931C300, 1'b1);
        repeat (7) tick();
        total++; if (val_w !== 1'b0) begin bad++; $display("FAIL xm32_early_valid got=%b want=0", val_w); end
        tick();
        total++; if (val_w !== 1'b1 || crc_w !== 16'h0000) begin bad++; $display("FAIL xm32_residue valid=%b crc=%h want 1/0000", val_w, crc_w); end
        total++; if (match_w !== CHK) begin bad++; $display("FAIL xm32_match got=%b want=%b", match_w, CHK); end
        cr32 = 1'b1;
        tick();
        cr32 = 1'b0;
        want = xmodem_word(32'h69F20000);
        send32(32'h69F20000, 1'b1);
        repeat (7) tick();
        total++; if (val_w !== 1'b0) begin bad++; $display("FAIL xm32_single_early got=%b want=0", val_w); end
        tick();
        total++; if (val_w !== 1'b1 || crc_w !== want) begin bad++; $display("FAIL xm32_single valid=%b crc=%h want 1/%h", val_w, crc_w, want); end
        total++; if (rdy_w !== 1'b0) begin bad++; $display("FAIL xm32_ready_in_done got=%b want=0", rdy_w); end
        cr32 = 1'b1;
        tick();
        cr32 = 1'b0;
        total++; if (rdy_w !== 1'b1 || val_w !== 1'b0) begin bad++; $display("FAIL xm32_release ready=%b valid=%b want 1/0", rdy_w, val_w); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_xmodem32();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/ip_codma_crc_stream.md
IP_CODMA_CRC_STREAM -- requirements
Module: ip_codma_crc_stream

Interface
REQ-001 The block SHALL have these parameters:
- CRC_W, 16, CRC register width; legal range 8..32.
- POLY, 'h1021, generator polynomial without the implicit x^CRC_W term.
- INIT, 'hFFFF, CRC register value at message start.
- XOR_OUT, 'h0000, value XORed onto the final result.
- DATA_W, 32, input word width.
- BITS_PER_CYCLE, 8, bits folded per SHIFT cycle; DATA_W % BITS_PER_CYCLE == 0.
- REFLECT_IN, 0, input bit order: 1 = LSB-first.
- REFLECT_OUT, 0, 1 = bit-reverse the result before XOR_OUT.

REQ-002 The block SHALL have these ports:
- clk_i  input  1  clock.
- reset_n_i  input  1  reset, asynchronous, active-low.
- clear_i  input  1  synchronous abort; reloads INIT.
- data_i  input  DATA_W  message word.
- data_valid_i  input  1  data_i valid.
- data_last_i  input  1  final word of the message.
- data_ready_o  output  1  block can accept a word.
- crc_o  output  CRC_W  final CRC; zero when crc_valid_o is low.
- crc_valid_o  output  1  crc_o valid.
- crc_ready_i  input  1  consumer accepts crc_o.
- expect_i  input  CRC_W  expected CRC for the check.
- crc_match_o  output  1  check result.

REQ-003 Illegal parameter combinations SHALL raise an elaboration-time error.

Function
REQ-004 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-005 data_ready_o SHALL be 1 only in IDLE.
REQ-006 A word SHALL be accepted when data_valid_i and data_ready_o are both 1; data_i and data_last_i are captured and the FSM moves to SHIFT.
REQ-007 SHIFT SHALL last exactly N = DATA_W/BITS_PER_CYCLE cycles, each folding BITS_PER_CYCLE bits, tracked by a beat counter 0..N-1.
- After the final beat the FSM moves to DONE if last was captured, else to IDLE.
- Word-to-word acceptance period is N+1 cycles.
REQ-008 Bit feed order SHALL be:
- REFLECT_IN=0: data_i[DATA_W-1] down to data_i[0] (big-endian bytes).
- REFLECT_IN=1: data_i[0] up to data_i[DATA_W-1] (little-endian, byte-reflected).
REQ-009 The per-bit step SHALL be: fb = crc[CRC_W-1] ^ bit; crc = (crc << 1) ^ (fb ? POLY : 0), truncated to CRC_W bits.
REQ-010 In DONE:
- crc_valid_o = 1.
- crc_o = (REFLECT_OUT ? bitrev(crc) : crc) ^ XOR_OUT, held stable until crc_ready_i is 1.
- On that handshake, crc reloads INIT and the FSM moves to IDLE in the next cycle.
REQ-011 clear_i SHALL take priority over all other events in every state.
- Next cycle: state IDLE, crc = INIT, beat counter 0, crc_valid_o 0.
- A word offered in the same cycle is not accepted.
- A result handshaking in the same cycle is discarded.
REQ-012 A message of one word with data_last_i=1 SHALL be legal; data_last_i SHALL be sampled only on acceptance.
REQ-013 crc_valid_o and data_ready_o SHALL never both be 1.

Reset
REQ-014 Asserting reset_n_i SHALL immediately force: state IDLE, crc = INIT, beat counter 0, captured word 0, crc_valid_o 0, crc_o 0, crc_match_o 0.
REQ-015 Reset asserted mid-SHIFT or in DONE SHALL discard the partial message or result without any output pulse.
REQ-016 data_ready_o SHALL be 1 from the first clock edge after reset release.

Configuration
REQ-017 The macro CODMA_CRC_CHECK_EN SHALL control the check function.
- Defined: crc_match_o = crc_valid_o & (crc_o == expect_i), combinational.
- Undefined: crc_match_o is tied 0, expect_i is unused and no comparator is synthesised.
- Port list is identical in both cases.

Structure
REQ-018 Package ip_codma_crc_pkg SHALL hold:
- the FSM state enum;
- preset constants CRC16_CCITT_POLY = 'h1021 and CRC32_POLY = 'h04C11DB7;
- a parametric bit-reverse function.
REQ-019 Sub-module ip_codma_crc_step SHALL be the combinational BITS_PER_CYCLE-bit fold (CRC_W, POLY parameters; crc in, bits in, crc out), instantiated once.

Verification
REQ-020 CCITT-FALSE (DATA_W=8, BITS_PER_CYCLE=8): "123456789" as 9 words, last on word 9 -> crc_o = 'h29B1, crc_valid_o asserted N+1 cycles after the last acceptance.
REQ-021 XMODEM (INIT=0, DATA_W=32, BITS_PER_CYCLE=4): words 'h31323334, 'h35363738, then DATA_W=8 run of 'h39 per config -> 'h31C3; single word 'h69F20000 with last -> software-model value, 8-cycle SHIFT.
REQ-022 CRC-32 (CRC_W=32, POLY='h04C11DB7, INIT=XOR_OUT='hFFFFFFFF, reflect on, DATA_W=8): "123456789" -> 'hCBF43926.
REQ-023 Backpressure: hold crc_ready_i low 5 cycles in DONE -> crc_o stable, data_ready_o 0 throughout; release -> IDLE next cycle, next message unaffected.
REQ-024 Abort and reset: clear_i mid-SHIFT of word 2 -> IDLE, then a full "123456789" run gives 'h29B1; repeat with reset_n_i low 1 cycle -> same.
REQ-025 Check (macro defined): expect_i = 'h29B1 -> crc_match_o = 1 during DONE; expect_i = 'h29B0 -> 0; macro undefined -> crc_match_o constantly 0.
